// File: rtl/comp_ctrl_sequencer.sv
// rtl/comp_ctrl_sequencer.sv - Avalon-MM step-table sequencer for component-control lines
//
// Purpose: owns the OUT_W control lines. When idle the lines follow the
// MANUAL register; on start they replay a programmable table of
// {value, hold} steps, each step holding its value for max(hold,1) clocks.
//
// Ports:
//   clk         in   1      clock
//   reset_n     in   1      asynchronous active-low reset
//   address     in   3      word address
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data
//   readdata    out  32     combinational read data, zero wait states
//   out_port    out  OUT_W  registered control lines
//   irq         out  1      done & irq_en
//
// Register map (unused bits read 0):
//   0 MANUAL  RW [OUT_W-1:0]
//   1 CTRL    W bit0 start, bit1 abort (self-clearing); RW bit2 loop, bit3 irq_en
//   2 STATUS  R bit0 busy, bit1 done, [8+:PTR_W] cur_step; W1C bit1 done
//   3 PTR     RW table pointer
//   4 TDATA   RW {hold[31:16], value} of entry PTR; write post-increments PTR
//   5 LENGTH  RW step count, saturates at DEPTH

module comp_ctrl_sequencer #(
  parameter int OUT_W     = 3,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 16,
  parameter int RESET_VAL = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [OUT_W-1:0] out_port,
  output logic             irq
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_L = (PTR_W+1)'(DEPTH);
  localparam logic [OUT_W-1:0] RST_OUT = OUT_W'(RESET_VAL);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state, state_nxt;

  logic [OUT_W-1:0] manual;
  logic             loop;
  logic             irq_en;
  logic             done;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   length;
  logic [PTR_W-1:0] cur_step;
  logic [CNT_W-1:0] cnt;

  logic [OUT_W-1:0] tbl_value [DEPTH];
  logic [CNT_W-1:0] tbl_hold  [DEPTH];

  // Bus decode
  logic wr_en;
  logic start;
  logic abort;
  logic done_w1c;

  assign wr_en    = chipselect & ~write_n;
  // Abort takes priority, so a combined start+abort write never launches a run.
  assign start    = wr_en && (address == 3'd1) && writedata[0] && !writedata[1];
  assign abort    = wr_en && (address == 3'd1) && writedata[1];
  assign done_w1c = wr_en && (address == 3'd2) && writedata[1];

  // Sequencer control
  logic [PTR_W:0]   step_nxt;
  logic             last_step;
  logic             load_en;
  logic [PTR_W-1:0] load_idx;
  logic             set_done;
  logic             clr_done;

  assign step_nxt  = {1'b0, cur_step} + (PTR_W+1)'(1);
  // ">=" rather than "==" so a LENGTH shrunk mid-run still terminates.
  assign last_step = (step_nxt >= length);

  function automatic logic [CNT_W-1:0] eff_hold(input logic [CNT_W-1:0] h);
    return (h == '0) ? CNT_W'(1) : h;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    load_idx  = '0;
    set_done  = 1'b0;
    clr_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_nxt = S_RUN;
            load_en   = 1'b1;
            load_idx  = '0;
            clr_done  = 1'b1;
          end else begin
            set_done  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          if (!last_step) begin
            load_en  = 1'b1;
            load_idx = step_nxt[PTR_W-1:0];
          end else if (loop) begin
            load_en  = 1'b1;
            load_idx = '0;
          end else begin
            state_nxt = S_IDLE;
            set_done  = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Step table: no reset, contents undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en && (address == 3'd4)) begin
      tbl_value[ptr] <= writedata[OUT_W-1:0];
      tbl_hold[ptr]  <= writedata[16 +: CNT_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      manual   <= RST_OUT;
      out_port <= RST_OUT;
      loop     <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      ptr      <= '0;
      length   <= '0;
      cur_step <= '0;
      cnt      <= '0;
    end else begin
      if (wr_en) begin
        case (address)
          3'd0: manual <= writedata[OUT_W-1:0];
          3'd1: begin
            loop   <= writedata[2];
            irq_en <= writedata[3];
          end
          3'd3: ptr <= writedata[PTR_W-1:0];
          3'd4: ptr <= ptr + PTR_W'(1);
          3'd5: length <= (writedata > 32'(DEPTH)) ? DEPTH_L : writedata[PTR_W:0];
          default: ;
        endcase
      end

      // A completion in the same cycle as a W1C keeps done set.
      if (set_done) begin
        done <= 1'b1;
      end else if (clr_done || done_w1c) begin
        done <= 1'b0;
      end

      if (load_en) begin
        out_port <= tbl_value[load_idx];
        cnt      <= eff_hold(tbl_hold[load_idx]);
        cur_step <= load_idx;
      end else if (state_nxt == S_IDLE) begin
        out_port <= manual;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign irq = done & irq_en;

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata[OUT_W-1:0] = manual;
      3'd1: begin
        readdata[2] = loop;
        readdata[3] = irq_en;
      end
      3'd2: begin
        readdata[0]          = (state == S_RUN);
        readdata[1]          = done;
        readdata[8 +: PTR_W] = cur_step;
      end
      3'd3: readdata[PTR_W-1:0] = ptr;
      3'd4: begin
        readdata[OUT_W-1:0]  = tbl_value[ptr];
        readdata[16 +: CNT_W] = tbl_hold[ptr];
      end
      3'd5: readdata[PTR_W:0] = length;
      default: ;
    endcase
  end

endmodule
